uart_tx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_tx_frame_ctrl
// PURPOSE
// - Sequences one UART transmit frame per accepted byte: START, DATA (LSB first), optional PARITY, STOP.
// - Sits between the AXI-side TX buffer (valid/ready byte stream) and the serial pin.
// - Owns the bit-period counter and the uart_state_t sequencing.
// - Frame format comes from a uart_config_t supplied by the config register block.
// PARAMETERS
// - DIV_WIDTH     16   width of baud divisor (clocks per bit)
// - MAX_DATA_BITS 8    upper clamp for numDataBits
// PORTS
// - clk_i        in   1          single clock
// - rst_i        in   1          synchronous, active-high reset
// - cfg_i        in   uart_config_t  frame format; sampled only at frame acceptance
// - baud_div_i   in   DIV_WIDTH  clocks per bit; sampled at frame acceptance
// - tx_data_i    in   8          byte to send
// - tx_valid_i   in   1          byte available
// - tx_ready_o   out  1          controller can accept a byte
// - tx_o         out  1          serial line, idle high
// - busy_o       out  1          frame in progress
// - tx_done_o    out  1          one-cycle pulse at end of last stop bit
// - state_o      out  uart_state_t  current FSM state (debug/coverage)
// BEHAVIOUR
// - Reset (sync, rst_i=1 at posedge): state IDLE, tx_o=1, busy_o=0, tx_done_o=0. Counters cleared. Any frame in progress is dropped. tx_o returns high the cycle after reset is sampled.
// - tx_ready_o = (state==IDLE) && !rst_i, combinational. Accept on tx_valid_i && tx_ready_o.
// - On accept: latch tx_data_i, cfg_i and baud_div_i; go to START. tx_o=0 from the next cycle.
// - Config changes outside acceptance have no effect on the current frame.
// - Latched divisor 0 is treated as 1. Each bit lasts exactly div cycles. A down-counter reloads at each bit boundary.
// - numDataBits is clamped to [5, MAX_DATA_BITS]. numStopBits 0 is treated as 1; values >=2 mean 2.
// - FSM:
//   - IDLE -> START on accept.
//   - START -> DATA after 1 bit.
//   - DATA shifts LSB first. After N bits -> PARITY if parityEnable, else STOP.
//   - PARITY -> STOP after 1 bit.
//   - STOP -> IDLE after the stop-bit count.
// - Parity bit = XOR of the N transmitted data bits, inverted when parityType=1 (odd). Bits above N are ignored.
// - tx_o: START=0, DATA=data bit, PARITY=parity, STOP=1, IDLE=1.
// - tx_done_o pulses in the cycle STOP->IDLE is taken. busy_o=1 in every state except IDLE.
// - Back-to-back: IDLE is held for at least 1 cycle. With tx_valid_i held, the next START begins 1 cycle after tx_done_o.
// - Frame length in clocks = div * (1 + N + parityEnable + stop). Acceptance-to-tx_done_o = that value.
// - baudRate field of uart_config_t is informational only. The divisor comes solely from baud_div_i.
// STRUCTURE
// - Existing shared package supplies uart_state_t and uart_config_t.
// - Add to the shared package: UART_MIN_DATA_BITS=5, UART_MAX_STOP_BITS=2.
// - One natural sub-module: uart_baud_counter. It is a loadable down-counter with a bit_tick output.
// - FSM, shifter and parity stay in this module.
// TESTING
// - 8N1, div=4, 0xA5 accepted:
//   - tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
//   - tx_done_o 40 cycles after accept.
//   - tx_ready_o low throughout the frame.
// - 7E2, div=2, 0x41:
//   - data bits 1,0,0,0,0,0,1, then parity 0, then two stop bits.
//   - frame length 22 cycles.
//   - repeat with odd parity -> parity bit 1.
// - numDataBits=12, numStopBits=0:
//   - behaves as 8 data bits and 1 stop bit.
//   - baud_div_i=0 gives 1-cycle bits, 10-cycle frame.
// - Config/divisor changed mid-frame (8N1 -> 5O2, div 4 -> 8):
//   - current frame unchanged.
//   - next accepted frame uses the new format.
// - rst_i asserted during DATA:
//   - next cycle: state IDLE, tx_o=1, busy_o=0, no tx_done_o.
//   - a new byte after reset sends a clean frame.
// - tx_valid_i held high for 3 bytes, 8N1, div=3:
//   - three frames of 30 cycles, each separated by exactly 1 idle cycle.
//   - exactly 3 accepts and 3 tx_done_o pulses.

Source files
------------

// File: rtl/uart_tx_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_frame_ctrl_pkg
// Brief   : Shared UART types, frame-format limits and clamp helpers.
// Revision: 1.0 - initial release
// ============================================================================
package uart_tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_t;

  typedef struct packed {
    logic [31:0] baudRate;      // informational only
    logic [3:0]  numDataBits;
    logic [1:0]  numStopBits;
    logic        parityEnable;
    logic        parityType;    // 0 = even, 1 = odd
  } uart_config_t;

  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_STOP_BITS = 2;

  // Clamp the requested data-bit count into [UART_MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] uart_clamp_data_bits(input logic [3:0] n,
                                                      input logic [3:0] max_bits);
    if (n < 4'(UART_MIN_DATA_BITS)) return 4'(UART_MIN_DATA_BITS);
    else if (n > max_bits)          return max_bits;
    else                            return n;
  endfunction

  // Zero stop bits means one; anything at or above the maximum means the maximum.
  function automatic logic [1:0] uart_clamp_stop_bits(input logic [1:0] n);
    if (n == 2'd0)                          return 2'd1;
    else if (n >= 2'(UART_MAX_STOP_BITS))   return 2'(UART_MAX_STOP_BITS);
    else                                    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl_baud_counter.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_counter
// Brief   : Loadable bit-period down-counter; o_bit_tick marks the last clock
//           of each bit period and the counter reloads itself on that clock.
// Revision: 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_clear,
  output logic                 o_bit_tick
);

  localparam logic [DIV_WIDTH-1:0] c_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_count;
  logic                 r_run;
  logic [DIV_WIDTH-1:0] w_div_eff;

  // A divisor of zero would never tick, so it runs as one clock per bit.
  assign w_div_eff  = (i_div == '0) ? c_ONE : i_div;
  assign o_bit_tick = r_run && (r_count == '0);

  // Latch the divisor at load, then count down and reload at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= c_ONE;
      r_count <= '0;
      r_run   <= 1'b0;
    end else if (i_load) begin
      r_div   <= w_div_eff;
      r_count <= w_div_eff - c_ONE;
      r_run   <= 1'b1;
    end else if (i_clear) begin
      r_count <= '0;
      r_run   <= 1'b0;
    end else if (r_run) begin
      if (r_count == '0) r_count <= r_div - c_ONE;
      else               r_count <= r_count - c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_frame_ctrl
// Brief   : Sequences one UART frame (START, DATA LSB first, optional PARITY,
//           STOP) per accepted byte. Format and divisor are latched at accept.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH     = 16,
  parameter int MAX_DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  uart_config_t         cfg_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic [7:0]           tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 tx_done_o,
  output uart_state_t          state_o
);

  localparam logic [3:0] c_MAX_DATA_BITS = 4'(MAX_DATA_BITS);

  uart_state_t r_state;
  logic [7:0]  r_shift;
  logic [3:0]  r_bit_cnt;
  logic [3:0]  r_nbits;
  logic [1:0]  r_nstop;
  logic [1:0]  r_stop_cnt;
  logic        r_par_en;
  logic        r_par_type;
  logic        r_parity;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;

  logic w_accept;
  logic w_tick;
  logic w_bit_last;
  logic w_stop_last;
  logic w_clear;
  logic w_unused_cfg;

  assign tx_ready_o   = (r_state == UART_IDLE) && !rst_i;
  assign w_accept     = tx_valid_i && tx_ready_o;
  assign w_bit_last   = (r_bit_cnt == r_nbits - 4'd1);
  assign w_stop_last  = (r_stop_cnt == r_nstop - 2'd1);
  assign w_clear      = w_tick && (r_state == UART_STOP) && w_stop_last;
  assign w_unused_cfg = ^cfg_i.baudRate;

  assign tx_o      = r_tx;
  assign busy_o    = r_busy;
  assign tx_done_o = r_done;
  assign state_o   = r_state;

  uart_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_counter (
    .clk        (clk_i),
    .rst        (rst_i),
    .i_load     (w_accept),
    .i_div      (baud_div_i),
    .i_clear    (w_clear),
    .o_bit_tick (w_tick)
  );

  // Frame sequencer: state, shifter, running parity and registered line/status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= UART_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_nbits    <= c_MAX_DATA_BITS;
      r_nstop    <= 2'd1;
      r_stop_cnt <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        UART_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_shift    <= tx_data_i;
            r_nbits    <= uart_clamp_data_bits(cfg_i.numDataBits, c_MAX_DATA_BITS);
            r_nstop    <= uart_clamp_stop_bits(cfg_i.numStopBits);
            r_par_en   <= cfg_i.parityEnable;
            r_par_type <= cfg_i.parityType;
            r_state    <= UART_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        UART_START: begin
          if (w_tick) begin
            r_state   <= UART_DATA;
            r_tx      <= r_shift[0];
            r_parity  <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
        end
        UART_DATA: begin
          if (w_tick) begin
            if (w_bit_last) begin
              if (r_par_en) begin
                r_state <= UART_PARITY;
                r_tx    <= r_parity ^ r_par_type;
              end else begin
                r_state    <= UART_STOP;
                r_tx       <= 1'b1;
                r_stop_cnt <= '0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_tx      <= r_shift[0];
              r_parity  <= r_parity ^ r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        UART_PARITY: begin
          if (w_tick) begin
            r_state    <= UART_STOP;
            r_tx       <= 1'b1;
            r_stop_cnt <= '0;
          end
        end
        UART_STOP: begin
          if (w_tick) begin
            if (w_stop_last) begin
              r_state <= UART_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stop_cnt <= r_stop_cnt + 2'd1;
            end
          end
        end
        default: begin
          r_state <= UART_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_frame_ctrl
// Brief   : Directed, table-driven bench for uart_tx_frame_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_ctrl;
  import uart_tx_frame_ctrl_pkg::*;

  logic         clk;
  logic         rst_i;
  uart_config_t cfg_i;
  logic [15:0]  baud_div_i;
  logic [7:0]   tx_data_i;
  logic         tx_valid_i;
  logic         tx_ready_o;
  logic         tx_o;
  logic         busy_o;
  logic         tx_done_o;
  uart_state_t  state_o;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_frame_ctrl #(
    .DIV_WIDTH     (16),
    .MAX_DATA_BITS (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cfg_i      (cfg_i),
    .baud_div_i (baud_div_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .tx_done_o  (tx_done_o),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bit p is the line level during bit period p (bit 0 = start bit).
  typedef struct {
    logic [7:0]  data;
    logic [3:0]  nbits;
    logic [1:0]  nstop;
    logic        pen;
    logic        ptype;
    logic [15:0] div;
    int          dive;
    int          nper;
    logic [11:0] exp;
    logic        chg;
  } vec_t;

  vec_t vecs[6];

  function automatic uart_config_t mk_cfg(input logic [3:0] nb, input logic [1:0] ns,
                                          input logic pe, input logic pt);
    uart_config_t c;
    c.baudRate     = 32'd115200;
    c.numDataBits  = nb;
    c.numStopBits  = ns;
    c.parityEnable = pe;
    c.parityType   = pt;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Send one byte and check every clock of the frame plus the done pulse.
  task automatic run_frame(input vec_t v, input int idx);
    @(negedge clk);
    cfg_i      = mk_cfg(v.nbits, v.nstop, v.pen, v.ptype);
    baud_div_i = v.div;
    tx_data_i  = v.data;
    tx_valid_i = 1'b1;
    #1;
    check($sformatf("v%0d ready_before", idx), 32'(tx_ready_o), 32'd1);
    @(posedge clk);
    #1;
    tx_valid_i = 1'b0;
    for (int p = 0; p < v.nper; p++) begin
      for (int c = 0; c < v.dive; c++) begin
        if (v.chg && p == 3 && c == 0) begin
          cfg_i      = mk_cfg(4'd5, 2'd2, 1'b1, 1'b1);
          baud_div_i = 16'd8;
          tx_data_i  = 8'h13;
          tx_valid_i = 1'b1;
        end
        check($sformatf("v%0d tx_o p%0d c%0d", idx, p, c), 32'(tx_o), 32'(v.exp[p]));
        check($sformatf("v%0d ready_low p%0d", idx, p), 32'(tx_ready_o), 32'd0);
        check($sformatf("v%0d busy p%0d", idx, p), 32'(busy_o), 32'd1);
        check($sformatf("v%0d done_early p%0d", idx, p), 32'(tx_done_o), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    tx_valid_i = 1'b0;
    check($sformatf("v%0d done_pulse", idx), 32'(tx_done_o), 32'd1);
    check($sformatf("v%0d state_idle", idx), 32'(state_o), 32'(UART_IDLE));
    check($sformatf("v%0d tx_idle", idx), 32'(tx_o), 32'd1);
    check($sformatf("v%0d busy_idle", idx), 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d done_one_cycle", idx), 32'(tx_done_o), 32'd0);
  endtask

  int acc_cyc[8];
  int done_cyc[8];
  int n_acc;
  int n_done;
  int cyc;
  logic acc;
  vec_t v_clean;

  initial begin
    // 8N1 div4 0xA5: 0,1,0,1,0,0,1,0,1,1 ; format changed to 5O2/div8 mid-frame
    vecs[0] = '{8'hA5, 4'd8, 2'd1, 1'b0, 1'b0, 16'd4, 4, 10, 12'b0011_0100_1010, 1'b1};
    // 5O2 div8 0x13: data 1,1,0,0,1 parity 0 -> 0,1,1,0,0,1,0,1,1
    vecs[1] = '{8'h13, 4'd5, 2'd2, 1'b1, 1'b1, 16'd8, 8, 9,  12'b0001_1010_0110, 1'b0};
    // 7E2 div2 0x41: 0,1,0,0,0,0,0,1,0,1,1
    vecs[2] = '{8'h41, 4'd7, 2'd2, 1'b1, 1'b0, 16'd2, 2, 11, 12'b0110_1000_0010, 1'b0};
    // 7O2 div2 0x41: parity bit becomes 1
    vecs[3] = '{8'h41, 4'd7, 2'd2, 1'b1, 1'b1, 16'd2, 2, 11, 12'b0111_1000_0010, 1'b0};
    // 12 data bits, 0 stop, div0 -> 8N1 at 1 clk/bit, 0x3C: 0,0,0,1,1,1,1,0,0,1
    vecs[4] = '{8'h3C, 4'd12, 2'd0, 1'b0, 1'b0, 16'd0, 1, 10, 12'b0010_0111_1000, 1'b0};
    // 2 data bits -> 5, 3 stop -> 2, even parity, 0xFF: 0,1,1,1,1,1,1,1,1
    vecs[5] = '{8'hFF, 4'd2, 2'd3, 1'b1, 1'b0, 16'd1, 1, 9,  12'b0001_1111_1110, 1'b0};

    rst_i      = 1'b1;
    cfg_i      = mk_cfg(4'd8, 2'd1, 1'b0, 1'b0);
    baud_div_i = 16'd4;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst tx_o", 32'(tx_o), 32'd1);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(tx_done_o), 32'd0);
    check("rst state", 32'(state_o), 32'(UART_IDLE));
    check("rst ready_low", 32'(tx_ready_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("post_rst ready", 32'(tx_ready_o), 32'd1);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Reset in the middle of the data bits.
    @(negedge clk);
    cfg_i      = mk_cfg(4'd8, 2'd1, 1'b0, 1'b0);
    baud_div_i = 16'd4;
    tx_data_i  = 8'hA5;
    tx_valid_i = 1'b1;
    @(posedge clk);
    #1;
    tx_valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid state_data", 32'(state_o), 32'(UART_DATA));
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("mid_rst ready_low", 32'(tx_ready_o), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst state", 32'(state_o), 32'(UART_IDLE));
    check("mid_rst tx_o", 32'(tx_o), 32'd1);
    check("mid_rst busy", 32'(busy_o), 32'd0);
    check("mid_rst done", 32'(tx_done_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("after_rst done k%0d", k), 32'(tx_done_o), 32'd0);
      check($sformatf("after_rst tx k%0d", k), 32'(tx_o), 32'd1);
    end
    v_clean = vecs[0];
    v_clean.chg = 1'b0;
    run_frame(v_clean, 6);

    // Back-to-back: valid held for three bytes, 8N1 div3.
    cfg_i      = mk_cfg(4'd8, 2'd1, 1'b0, 1'b0);
    baud_div_i = 16'd3;
    tx_data_i  = 8'h11;
    tx_valid_i = 1'b1;
    n_acc  = 0;
    n_done = 0;
    cyc    = 0;
    for (int k = 0; k < 8; k++) begin
      acc_cyc[k]  = -1000;
      done_cyc[k] = -1000;
    end
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      acc = tx_valid_i && tx_ready_o;
      @(posedge clk);
      cyc++;
      #1;
      if (tx_done_o) begin
        if (n_done < 8) done_cyc[n_done] = cyc;
        n_done++;
      end
      if (acc) begin
        if (n_acc < 8) acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc >= 3) tx_valid_i = 1'b0;
        else            tx_data_i = tx_data_i + 8'h22;
      end
    end
    check("b2b accepts", 32'(n_acc), 32'd3);
    check("b2b dones", 32'(n_done), 32'd3);
    check("b2b gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd31);
    check("b2b gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd31);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b len%0d", k), 32'(done_cyc[k] - acc_cyc[k]), 32'd30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
